// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline package for the memory port arbiter.
// Holds the arbiter state encoding, the default access timeout, bus widths,
// the registered memory command payload and a word-alignment helper.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } arb_state_e;

  // Command presented on the shared memory port while m_req is high
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Word accesses only: the two low address bits must be zero
  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline-side and memory-side signals around the arbiter.
// slave  : the arbiter's view (pipeline requests and memory responses in).
// master : the surrounding pipeline/memory view (requests out, results in).
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  // data port
  logic              memread;
  logic              memwrite;
  logic [ADDR_W-1:0] alu_result;
  logic [DATA_W-1:0] rdata2out;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  // status
  logic              err;
  logic              stall;
  // shared memory port
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;

  modport slave (
    input  if_req, if_addr, memread, memwrite, alu_result, rdata2out,
           m_rdata, m_ack,
    output if_rdata, if_valid, mem_rdata, mem_done, err, stall,
           m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, memread, memwrite, alu_result, rdata2out,
           m_rdata, m_ack,
    input  if_rdata, if_valid, mem_rdata, mem_done, err, stall,
           m_req, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Wait counter for an outstanding memory request.
// Ports: clk, rst (async, active-high); clear - zero the count;
// enable - count one waiting cycle; expired - this is the last allowed
// waiting cycle (count has reached TIMEOUT-1).
module mem_arb_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // Cycles spent with m_req high and no m_ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch stage and the MEM stage onto one memory port.
// Ports: clk, rst (async, active-high); bus (mem_port_arbiter_if.slave):
//   fetch  : if_req/if_addr in, if_rdata/if_valid out
//   data   : memread/memwrite/alu_result/rdata2out in, mem_rdata/mem_done out
//   status : err (qualifies a done pulse), stall (combinational freeze)
//   memory : m_req/m_we/m_addr/m_wdata out, m_rdata/m_ack in
// Data requests always win over fetch; malformed requests complete with err
// on the next cycle without touching the memory port.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  arb_state_e        state;
  mem_cmd_t          cmd_q;
  logic              m_req_q;
  logic              if_valid_q;
  logic              mem_done_q;
  logic              err_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;

  logic data_pend;
  logic fetch_pend;
  logic data_bad;
  logic fetch_bad;
  logic busy;
  logic timer_clear;
  logic timer_en;
  logic expired;

  // A port whose done pulse is high is not pending, so it cannot be regranted
  assign data_pend  = (bus.memread | bus.memwrite) & ~mem_done_q;
  assign fetch_pend = bus.if_req & ~if_valid_q;
  assign data_bad   = (bus.memread & bus.memwrite) | ~word_aligned(bus.alu_result[1:0]);
  assign fetch_bad  = ~word_aligned(bus.if_addr[1:0]);
  assign busy       = (state != IDLE);

  assign timer_clear = ~busy;
  assign timer_en    = busy & ~bus.m_ack;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  // Arbiter FSM with registered port outputs; done/err/rdata are one-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_q       <= '0;
      m_req_q     <= 1'b0;
      if_valid_q  <= 1'b0;
      mem_done_q  <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if_valid_q  <= 1'b0;
      mem_done_q  <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      unique case (state)
        IDLE: begin
          if (data_pend) begin
            if (data_bad) begin
              mem_done_q <= 1'b1;
              err_q      <= 1'b1;
            end else begin
              state       <= DATA;
              m_req_q     <= 1'b1;
              cmd_q.we    <= bus.memwrite;
              cmd_q.addr  <= bus.alu_result;
              cmd_q.wdata <= bus.memwrite ? bus.rdata2out : DATA_W'(0);
            end
          end else if (fetch_pend) begin
            if (fetch_bad) begin
              if_valid_q <= 1'b1;
              err_q      <= 1'b1;
            end else begin
              state       <= FETCH;
              m_req_q     <= 1'b1;
              cmd_q.we    <= 1'b0;
              cmd_q.addr  <= bus.if_addr;
              cmd_q.wdata <= DATA_W'(0);
            end
          end
        end
        DATA, FETCH: begin
          if (bus.m_ack) begin
            state   <= IDLE;
            m_req_q <= 1'b0;
            if (state == DATA) begin
              mem_done_q  <= 1'b1;
              mem_rdata_q <= cmd_q.we ? DATA_W'(0) : bus.m_rdata;
            end else begin
              if_valid_q <= 1'b1;
              if_rdata_q <= bus.m_rdata;
            end
          end else if (expired) begin
            // Abort: rdata stays at its zero default
            state   <= IDLE;
            m_req_q <= 1'b0;
            err_q   <= 1'b1;
            if (state == DATA) begin
              mem_done_q <= 1'b1;
            end else begin
              if_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          m_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_req     = m_req_q;
  assign bus.m_we      = cmd_q.we;
  assign bus.m_addr    = cmd_q.addr;
  assign bus.m_wdata   = cmd_q.wdata;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.err       = err_q;
  assign bus.stall     = ((bus.memread | bus.memwrite) & ~mem_done_q) |
                         (bus.if_req & ~if_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized
// transactions, each checked cycle by cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TO    = 16;
  localparam int NEVER = 1000;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Cycle (relative to the request) at which the done pulse is expected
  function automatic int done_cycle(input int start, input bit bad, input int dly);
    if (bad) return start + 1;
    if (dly <= TO - 1) return start + 2 + dly;
    return start + 1 + TO;
  endfunction

  task automatic drive_idle();
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.memread    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.alu_result = '0;
    bus.rdata2out  = '0;
    bus.m_rdata    = '0;
    bus.m_ack      = 1'b0;
  endtask

  // dk: 0 read, 1 write, 2 both controls. Delay = cycles from m_req rise to m_ack.
  task automatic run_txn(input bit dd, input int dk, input logic [31:0] da,
                         input logic [31:0] dw, input int ddl,
                         input bit ff, input logic [31:0] fa, input int fdl);
    bit dbad, fbad, derr, ferr, dwin, fwin, exp_done, exp_valid, rd, wr;
    int dend, fstart, fend, dack, fack, last;
    logic [31:0] dval, fval;
    dbad   = (dk == 2) || (da[1:0] != 2'b00);
    fbad   = (fa[1:0] != 2'b00);
    derr   = dbad || (ddl > TO - 1);
    ferr   = fbad || (fdl > TO - 1);
    dend   = dd ? done_cycle(0, dbad, ddl) : -1;
    fstart = dd ? dend : 0;
    fend   = ff ? done_cycle(fstart, fbad, fdl) : -1;
    // A malformed request gets an m_ack while the arbiter is idle, which must be ignored
    dack   = !dd ? -1 : (dbad ? 1 : (ddl == NEVER ? -1 : 1 + ddl));
    fack   = !ff ? -1 : (fbad ? fstart + 1 : (fdl == NEVER ? -1 : fstart + 1 + fdl));
    last   = ((dend > fend) ? dend : fend) + 1;
    dval   = '0;
    fval   = '0;
    for (int k = 0; k <= last; k++) begin
      rd = dd && (k <= dend) && (dk != 1);
      wr = dd && (k <= dend) && (dk != 0);
      bus.memread    = rd;
      bus.memwrite   = wr;
      bus.alu_result = da;
      bus.rdata2out  = dw;
      bus.if_req     = ff && (k <= fend);
      bus.if_addr    = fa;
      bus.m_ack      = (k == dack) || (k == fack);
      bus.m_rdata    = $urandom;
      if (k == dack) dval = bus.m_rdata;
      if (k == fack) fval = bus.m_rdata;
      #1;
      dwin      = dd && !dbad && (k >= 1) && (k < dend);
      fwin      = ff && !fbad && (k >= fstart + 1) && (k < fend);
      exp_done  = dd && (k == dend);
      exp_valid = ff && (k == fend);
      check("m_req", 32'(bus.m_req), 32'(dwin || fwin));
      if (dwin) begin
        check("m_addr_data", bus.m_addr, da);
        check("m_we_data", 32'(bus.m_we), 32'(dk == 1));
        if (dk == 1) check("m_wdata", bus.m_wdata, dw);
      end
      if (fwin) begin
        check("m_addr_fetch", bus.m_addr, fa);
        check("m_we_fetch", 32'(bus.m_we), 32'(0));
      end
      check("mem_done", 32'(bus.mem_done), 32'(exp_done));
      check("if_valid", 32'(bus.if_valid), 32'(exp_valid));
      check("err", 32'(bus.err), 32'((exp_done && derr) || (exp_valid && ferr)));
      if (exp_done) check("mem_rdata", bus.mem_rdata, (derr || dk == 1) ? 32'h0 : dval);
      if (exp_valid) check("if_rdata", bus.if_rdata, ferr ? 32'h0 : fval);
      check("stall", 32'(bus.stall),
            32'(((rd || wr) && !exp_done) || (bus.if_req && !exp_valid)));
      @(negedge clk);
    end
    drive_idle();
  endtask

  initial begin
    int r, dly[2];
    bit dd, ff;
    int dk;
    logic [31:0] da, fa;
    clk   = 1'b0;
    rst   = 1'b1;
    tests = 0;
    fails = 0;
    drive_idle();

    // Reset state: outputs zero, stall still follows the inputs
    repeat (2) @(negedge clk);
    bus.memread = 1'b1;
    #1;
    check("rst_m_req", 32'(bus.m_req), 32'(0));
    check("rst_mem_done", 32'(bus.mem_done), 32'(0));
    check("rst_if_valid", 32'(bus.if_valid), 32'(0));
    check("rst_err", 32'(bus.err), 32'(0));
    check("rst_m_addr", bus.m_addr, 32'h0);
    check("rst_stall_req", 32'(bus.stall), 32'(1));
    bus.memread = 1'b0;
    #1;
    check("rst_stall_idle", 32'(bus.stall), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Fetch with ack two cycles after m_req rises
    run_txn(1'b0, 0, 32'h0, 32'h0, 0, 1'b1, 32'h40, 2);
    // Data read and fetch together: data first, then fetch
    run_txn(1'b1, 0, 32'h100, 32'h0, 1, 1'b1, 32'h40, 0);
    // Store, immediate ack
    run_txn(1'b1, 1, 32'h104, 32'hDEADBEEF, 0, 1'b0, 32'h0, 0);
    // Misaligned load
    run_txn(1'b1, 0, 32'h102, 32'h0, 0, 1'b0, 32'h0, 0);
    // Conflicting controls
    run_txn(1'b1, 2, 32'h200, 32'h1234, 0, 1'b0, 32'h0, 0);
    // Load that is never acknowledged
    run_txn(1'b1, 0, 32'h108, 32'h0, NEVER, 1'b0, 32'h0, 0);
    // Ack on the last allowed cycle, and ack landing in the drop cycle
    run_txn(1'b0, 0, 32'h0, 32'h0, 0, 1'b1, 32'h44, TO - 1);
    run_txn(1'b0, 0, 32'h0, 32'h0, 0, 1'b1, 32'h48, TO);
    // Misaligned fetch
    run_txn(1'b0, 0, 32'h0, 32'h0, 0, 1'b1, 32'h4B, 0);

    // Reset in the middle of a fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    repeat (3) @(negedge clk);
    #1;
    check("mid_m_req_before", 32'(bus.m_req), 32'(1));
    rst = 1'b1;
    #1;
    check("mid_m_req_rst", 32'(bus.m_req), 32'(0));
    check("mid_if_valid_rst", 32'(bus.if_valid), 32'(0));
    check("mid_m_addr_rst", bus.m_addr, 32'h0);
    @(negedge clk);
    rst         = 1'b0;
    bus.if_req  = 1'b0;
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_m_req", 32'(bus.m_req), 32'(0));
      check("post_rst_if_valid", 32'(bus.if_valid), 32'(0));
      check("post_rst_mem_done", 32'(bus.mem_done), 32'(0));
    end
    drive_idle();
    @(negedge clk);
    // Counter must restart from zero after the abandoned access
    run_txn(1'b0, 0, 32'h0, 32'h0, 0, 1'b1, 32'h84, NEVER);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      dd = 1'($urandom_range(0, 1));
      ff = dd ? 1'($urandom_range(0, 1)) : 1'b1;
      r  = int'($urandom_range(0, 9));
      dk = (r < 4) ? 0 : (r < 8) ? 1 : 2;
      da = $urandom;
      fa = $urandom;
      if ($urandom_range(0, 4) != 0) da[1:0] = 2'b00;
      if ($urandom_range(0, 4) != 0) fa[1:0] = 2'b00;
      for (int j = 0; j < 2; j++) begin
        r = int'($urandom_range(0, 9));
        if (r < 6)       dly[j] = int'($urandom_range(0, 4));
        else if (r == 6) dly[j] = int'($urandom_range(5, TO - 1));
        else if (r == 7) dly[j] = TO;
        else             dly[j] = NEVER;
      end
      run_txn(dd, dk, da, $urandom, dly[0], ff, fa, dly[1]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles m_req may wait for m_ack before abort.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 if_req  in  1  fetch-stage read request, level, held until if_valid.
REQ-005 if_addr  in  32  fetch address.
REQ-006 if_rdata  out  32  fetched word, valid while if_valid high.
REQ-007 if_valid  out  1  one-cycle fetch-complete pulse.
REQ-008 memread, memwrite  in  1 each  MEM-stage controls from the EX/MEM latch, level, held until mem_done.
REQ-009 alu_result  in  32  data address; rdata2out  in  32  store data.
REQ-010 mem_rdata  out  32  load data, valid while mem_done high.
REQ-011 mem_done  out  1  one-cycle data-access-complete pulse.
REQ-012 err  out  1  qualifies a done pulse: access failed (misaligned, conflicting controls, timeout).
REQ-013 stall  out  1  combinational pipeline freeze.
REQ-014 m_req, m_we  out  1 each; m_addr, m_wdata  out  32 each; m_rdata  in  32; m_ack  in  1: shared memory port.

Function
REQ-015 States SHALL be IDLE, DATA, FETCH.
REQ-016 IDLE with memread|memwrite pending SHALL go to DATA, else with if_req SHALL go to FETCH; data always beats fetch.
REQ-017 No new grant SHALL be made to a port in the cycle its done pulse is high.
REQ-018 On grant, m_addr/m_wdata/m_we SHALL be registered and m_req asserted from the next cycle, held stable until m_ack or timeout.
REQ-019 m_ack in DATA/FETCH SHALL drop m_req next cycle, pulse the granted port's done with m_rdata captured, return to IDLE.
REQ-020 Minimum latency: request seen in cycle 0, m_req in cycle 1, m_ack in cycle 1 gives done in cycle 2.
REQ-021 Writes (m_we=1) SHALL return mem_rdata=0.
REQ-022 memread and memwrite both high SHALL not issue an access; mem_done and err pulse next cycle.
REQ-023 Data or fetch address with [1:0]!=0 SHALL not issue an access; done and err pulse next cycle.
REQ-024 Wait counter SHALL count cycles m_req high without m_ack; reaching TIMEOUT SHALL drop m_req, pulse done with err=1, rdata=0, go IDLE.
REQ-025 m_ack while IDLE or in the m_req drop cycle SHALL be ignored.
REQ-026 stall = ((memread|memwrite) & ~mem_done) | (if_req & ~if_valid).
REQ-027 err SHALL be low whenever no done pulse is high.

Reset
REQ-028 rst high SHALL force IDLE immediately, counter 0, all outputs 0 (stall follows REQ-026 from inputs).
REQ-029 rst mid-access SHALL abandon it without a done pulse; a later m_ack SHALL be ignored.

Structure
REQ-030 State enum and TIMEOUT default SHALL live in the shared pipeline package.
REQ-031 Wait counter SHALL be sub-module mem_arb_timer (inputs clear, enable; output expired).

Verification
REQ-032 if_req=1, if_addr=0x40, ack after 2 cycles, m_rdata=0x8C220004 -> if_valid pulse cycle 4, if_rdata=0x8C220004, stall low that cycle.
REQ-033 if_req and memread together, alu_result=0x100 -> m_addr=0x100 first, mem_done, then m_addr=0x40, if_valid.
REQ-034 memwrite=1, alu_result=0x104, rdata2out=0xDEADBEEF, ack=1 -> m_we=1, m_wdata=0xDEADBEEF, mem_done with mem_rdata=0.
REQ-035 memread=1, alu_result=0x102 -> no m_req, mem_done=err=1 next cycle.
REQ-036 memread=1, m_ack never -> m_req high 16 cycles, then mem_done=err=1, rdata=0.
REQ-037 rst pulsed during FETCH with m_req high -> m_req=0 at once, no if_valid, subsequent m_ack ignored.
